// File: rtl/tlk2711_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_pkg
// Description : Shared types, constants and helpers for the TLK2711 DMA
//               command blocks (RX write-command and TX read-command).
//               - rx_cmd_state_t : RX command generator FSM states
//               - ALIGN_BYTES    : DMA length granule in bytes
//               - pack_cmd()     : command word packing {addr (high), len (low)}
// Revision    : 1.0 - initial release
// ============================================================================
package tlk2711_pkg;

  localparam int unsigned ALIGN_BYTES = 8;

  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_ARMED     = 2'd1,
    RX_REQ       = 2'd2,
    RX_WAIT_DONE = 2'd3
  } rx_cmd_state_t;

  // Packs a command word as {addr, len} with len occupying the low dlen_w
  // bits. Operands are carried at 64 bits so any block width fits; the
  // caller narrows the result to its own command width.
  function automatic logic [127:0] pack_cmd(input logic [63:0]  addr,
                                            input logic [63:0]  len,
                                            input int unsigned  dlen_w);
    return ({64'b0, addr} << dlen_w) | {64'b0, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlk2711_len_align8.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_len_align8
// Description : Registered round-up of a 16-bit byte length to the next
//               multiple of ALIGN_BYTES. The output register loads only when
//               i_en is high, so it also serves as the config latch.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_en       - load strobe
//               i_len      - raw byte length
//               o_len_a    - aligned byte length (wraps to 0 above 0xFFF8)
// Revision    : 1.0 - initial release
// ============================================================================
module tlk2711_len_align8
  import tlk2711_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [15:0] i_len,
  output logic [15:0] o_len_a
);

  localparam int unsigned c_SHIFT = $clog2(ALIGN_BYTES);

  logic [15-c_SHIFT:0] w_units;
  logic [15:0]         r_len_a;

  // Whole granules plus one more when any sub-granule byte is present.
  assign w_units = i_len[15:c_SHIFT] + (16-c_SHIFT)'(|i_len[c_SHIFT-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_a <= '0;
    end else if (i_en) begin
      r_len_a <= {w_units, {c_SHIFT{1'b0}}};
    end
  end

  assign o_len_a = r_len_a;

endmodule
`default_nettype wire

// File: rtl/tlk2711_rx_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tlk2711_rx_cmd
// Description : RX DMA write-command generator. Each frame start from the
//               decoder becomes one write command {addr, len}; frames are laid
//               out contiguously (body frames, then an optional tail frame).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_soft_rst          - abort: state, counters, flags to reset
//               i_rx_start          - latch config and (re)arm the run
//               i_rx_base_addr/... - run configuration
//               i_rx_frame_start    - decoder frame-header pulse
//               o_wr_cmd_req/ack    - command handshake, o_wr_cmd_data payload
//               i_dma_wr_last       - DMA finished current frame
//               o_rx_frame_cnt, o_rx_busy, o_rx_done, o_rx_overflow - status
// Revision    : 1.0 - initial release
// ============================================================================
module tlk2711_rx_cmd
  import tlk2711_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DLEN_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_soft_rst,
  input  logic                             i_rx_start,
  input  logic [ADDR_WIDTH-1:0]            i_rx_base_addr,
  input  logic [15:0]                      i_rx_packet_body,
  input  logic [15:0]                      i_rx_packet_tail,
  input  logic [15:0]                      i_rx_body_num,
  input  logic                             i_rx_frame_start,
  output logic                             o_wr_cmd_req,
  input  logic                             i_wr_cmd_ack,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_wr_cmd_data,
  input  logic                             i_dma_wr_last,
  output logic [15:0]                      o_rx_frame_cnt,
  output logic                             o_rx_busy,
  output logic                             o_rx_done,
  output logic                             o_rx_overflow
);

  localparam int unsigned c_CMD_W = DLEN_WIDTH + ADDR_WIDTH;

  rx_cmd_state_t         r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [15:0]           r_cnt, w_cnt_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic [c_CMD_W-1:0]    r_cmd, w_cmd_nxt;

  logic [15:0]           r_body;
  logic [15:0]           r_body_num;
  logic                  r_tail_nz;

  logic [15:0]           w_body_a, w_tail_a;
  logic [16:0]           w_total_in, w_total;
  logic [15:0]           w_cnt_inc;
  logic                  w_final;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [15:0]           w_len_cur, w_len_nxt;

  // Aligners load on i_rx_start, so aligned lengths are ready the cycle the
  // block becomes ARMED.
  tlk2711_len_align8 u_body_align (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_rx_start),
    .i_len   (i_rx_packet_body),
    .o_len_a (w_body_a)
  );

  tlk2711_len_align8 u_tail_align (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_rx_start),
    .i_len   (i_rx_packet_tail),
    .o_len_a (w_tail_a)
  );

  // Frame totals are 17 bits: body_num = 0xFFFF plus a tail is 65536 frames.
  assign w_total_in = {1'b0, i_rx_body_num} + 17'(|i_rx_packet_tail);
  assign w_total    = {1'b0, r_body_num} + 17'(r_tail_nz);
  assign w_cnt_inc  = r_cnt + 16'd1;
  assign w_final    = ({1'b0, r_cnt} + 17'd1) == w_total;
  // Address advances by the raw body length so the layout matches TX.
  assign w_addr_inc = r_addr + ADDR_WIDTH'(r_body);
  assign w_len_cur  = (r_cnt < r_body_num) ? w_body_a : w_tail_a;
  assign w_len_nxt  = (w_cnt_inc < r_body_num) ? w_body_a : w_tail_a;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_cmd_nxt   = r_cmd;

    if (i_rx_start) begin
      w_addr_nxt  = i_rx_base_addr;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_cmd_nxt   = '0;
      if (w_total_in == 17'd0) begin
        w_state_nxt = RX_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = RX_ARMED;
      end
    end else if (i_soft_rst) begin
      w_state_nxt = RX_IDLE;
      w_addr_nxt  = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_cmd_nxt   = '0;
    end else begin
      case (r_state)
        RX_ARMED: begin
          if (i_rx_frame_start) begin
            w_state_nxt = RX_REQ;
            w_cmd_nxt   = c_CMD_W'(pack_cmd(64'(r_addr), 64'(w_len_cur), DLEN_WIDTH));
          end
        end
        RX_REQ: begin
          if (i_rx_frame_start) w_ovf_nxt = 1'b1;
          if (i_wr_cmd_ack)     w_state_nxt = RX_WAIT_DONE;
        end
        RX_WAIT_DONE: begin
          if (i_dma_wr_last) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_final) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = RX_IDLE;
              if (i_rx_frame_start) w_ovf_nxt = 1'b1;
            end else begin
              w_addr_nxt = w_addr_inc;
              // A frame start coinciding with completion belongs to the next
              // frame, so issue its command immediately.
              if (i_rx_frame_start) begin
                w_state_nxt = RX_REQ;
                w_cmd_nxt   = c_CMD_W'(pack_cmd(64'(w_addr_inc), 64'(w_len_nxt), DLEN_WIDTH));
              end else begin
                w_state_nxt = RX_ARMED;
              end
            end
          end else if (i_rx_frame_start) begin
            w_ovf_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RX_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_cmd      <= '0;
      r_body     <= '0;
      r_body_num <= '0;
      r_tail_nz  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cmd   <= w_cmd_nxt;
      if (i_rx_start) begin
        r_body     <= i_rx_packet_body;
        r_body_num <= i_rx_body_num;
        r_tail_nz  <= |i_rx_packet_tail;
      end
    end
  end

  assign o_wr_cmd_req   = (r_state == RX_REQ);
  assign o_wr_cmd_data  = r_cmd;
  assign o_rx_frame_cnt = r_cnt;
  assign o_rx_busy      = (r_state != RX_IDLE);
  assign o_rx_done      = r_done;
  assign o_rx_overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tlk2711_rx_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlk2711_rx_cmd
// Description : Self-checking bench for tlk2711_rx_cmd. Table of run configs
//               with expected frame counts, a command scoreboard checked at
//               every handshake, and hand-written corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlk2711_rx_cmd;

  logic        clk;
  logic        rst;
  logic        i_soft_rst;
  logic        i_rx_start;
  logic [31:0] i_rx_base_addr;
  logic [15:0] i_rx_packet_body;
  logic [15:0] i_rx_packet_tail;
  logic [15:0] i_rx_body_num;
  logic        i_rx_frame_start;
  logic        o_wr_cmd_req;
  logic        i_wr_cmd_ack;
  logic [47:0] o_wr_cmd_data;
  logic        i_dma_wr_last;
  logic [15:0] o_rx_frame_cnt;
  logic        o_rx_busy;
  logic        o_rx_done;
  logic        o_rx_overflow;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
  } cmd_t;

  typedef struct {
    logic [31:0] base;
    logic [15:0] body;
    logic [15:0] tail;
    logic [15:0] num;
    int          ack_dly;
    int          frames;
  } vec_t;

  cmd_t sb[$];

  tlk2711_rx_cmd #(.ADDR_WIDTH(32), .DLEN_WIDTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_soft_rst       (i_soft_rst),
    .i_rx_start       (i_rx_start),
    .i_rx_base_addr   (i_rx_base_addr),
    .i_rx_packet_body (i_rx_packet_body),
    .i_rx_packet_tail (i_rx_packet_tail),
    .i_rx_body_num    (i_rx_body_num),
    .i_rx_frame_start (i_rx_frame_start),
    .o_wr_cmd_req     (o_wr_cmd_req),
    .i_wr_cmd_ack     (i_wr_cmd_ack),
    .o_wr_cmd_data    (o_wr_cmd_data),
    .i_dma_wr_last    (i_dma_wr_last),
    .o_rx_frame_cnt   (o_rx_frame_cnt),
    .o_rx_busy        (o_rx_busy),
    .o_rx_done        (o_rx_done),
    .o_rx_overflow    (o_rx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] align8(input logic [15:0] x);
    logic [16:0] t;
    t = (({1'b0, x} + 17'd7) / 17'd8) * 17'd8;
    return t[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each handshake must carry the oldest expected command.
  always @(negedge clk) begin
    if (!rst && o_wr_cmd_req && i_wr_cmd_ack) begin
      if (sb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_cmd: got 0x%0h, expected no command", o_wr_cmd_data);
      end else begin
        cmd_t e;
        e = sb.pop_front();
        check("cmd_data", 64'(o_wr_cmd_data), 64'({e.addr, e.len}));
      end
    end
  end

  task automatic start_run(input logic [31:0] base, input logic [15:0] body,
                           input logic [15:0] tail, input logic [15:0] num);
    i_rx_base_addr   = base;
    i_rx_packet_body = body;
    i_rx_packet_tail = tail;
    i_rx_body_num    = num;
    i_rx_start       = 1'b1;
    tick();
    i_rx_start       = 1'b0;
    // Scramble config: it must be ignored until the next start.
    i_rx_base_addr   = $urandom;
    i_rx_packet_body = 16'($urandom);
    i_rx_packet_tail = 16'($urandom);
    i_rx_body_num    = 16'($urandom);
  endtask

  task automatic pulse_fs();
    i_rx_frame_start = 1'b1;
    tick();
    i_rx_frame_start = 1'b0;
  endtask

  task automatic ack_now();
    i_wr_cmd_ack = 1'b1;
    tick();
    i_wr_cmd_ack = 1'b0;
  endtask

  task automatic pulse_last();
    i_dma_wr_last = 1'b1;
    tick();
    i_dma_wr_last = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [15:0] l);
    cmd_t e;
    e.addr = a;
    e.len  = l;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    start_run(v.base, v.body, v.tail, v.num);
    check($sformatf("v%0d_busy_after_start", idx), 64'(o_rx_busy), 64'(v.frames != 0));
    if (v.frames == 0) begin
      check($sformatf("v%0d_empty_done", idx), 64'(o_rx_done), 64'd1);
      tick();
      check($sformatf("v%0d_empty_done_clear", idx), 64'(o_rx_done), 64'd0);
      return;
    end
    for (int k = 0; k < v.frames; k++) begin
      push_cmd(v.base + 32'(k) * {16'b0, v.body},
               (k < int'(v.num)) ? align8(v.body) : align8(v.tail));
      pulse_fs();
      check($sformatf("v%0d_f%0d_req", idx, k), 64'(o_wr_cmd_req), 64'd1);
      repeat (v.ack_dly) tick();
      ack_now();
      check($sformatf("v%0d_f%0d_req_drop", idx, k), 64'(o_wr_cmd_req), 64'd0);
      tick();
      pulse_last();
      check($sformatf("v%0d_f%0d_cnt", idx, k), 64'(o_rx_frame_cnt), 64'(k + 1));
      check($sformatf("v%0d_f%0d_done", idx, k), 64'(o_rx_done), 64'(k == v.frames - 1));
      check($sformatf("v%0d_f%0d_busy", idx, k), 64'(o_rx_busy), 64'(k != v.frames - 1));
    end
    tick();
    check($sformatf("v%0d_done_clear", idx), 64'(o_rx_done), 64'd0);
    check($sformatf("v%0d_sb_empty", idx), 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{base: 32'h1000_0000, body: 16'd870, tail: 16'd100, num: 16'd2, ack_dly: 3, frames: 3};
    vecs[1] = '{base: 32'h0000_4000, body: 16'd864, tail: 16'd0,   num: 16'd2, ack_dly: 0, frames: 2};
    vecs[2] = '{base: 32'hFFFF_FF00, body: 16'd256, tail: 16'd1,   num: 16'd1, ack_dly: 1, frames: 2};
    vecs[3] = '{base: 32'h0000_0008, body: 16'd8,   tail: 16'd7,   num: 16'd0, ack_dly: 2, frames: 1};
    vecs[4] = '{base: 32'h1234_5678, body: 16'd5,   tail: 16'd0,   num: 16'd0, ack_dly: 0, frames: 0};

    rst = 1'b1; i_soft_rst = 1'b0; i_rx_start = 1'b0;
    i_rx_base_addr = '0; i_rx_packet_body = '0; i_rx_packet_tail = '0; i_rx_body_num = '0;
    i_rx_frame_start = 1'b0; i_wr_cmd_ack = 1'b0; i_dma_wr_last = 1'b0;
    repeat (3) tick();
    check("rst_req",  64'(o_wr_cmd_req),   64'd0);
    check("rst_data", 64'(o_wr_cmd_data),  64'd0);
    check("rst_cnt",  64'(o_rx_frame_cnt), 64'd0);
    check("rst_busy", 64'(o_rx_busy),      64'd0);
    check("rst_done", 64'(o_rx_done),      64'd0);
    check("rst_ovf",  64'(o_rx_overflow),  64'd0);
    rst = 1'b0;
    tick();

    // Frame start while idle is ignored without a flag.
    pulse_fs();
    check("idle_fs_req", 64'(o_wr_cmd_req),  64'd0);
    check("idle_fs_ovf", 64'(o_rx_overflow), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Overflow: frame starts in REQ and in WAIT_DONE are dropped and flagged.
    start_run(32'h1000_0000, 16'd870, 16'd100, 16'd2);
    push_cmd(32'h1000_0000, 16'd872);
    pulse_fs();
    pulse_fs();
    check("ovf_req_flag", 64'(o_rx_overflow), 64'd1);
    check("ovf_req_held", 64'(o_wr_cmd_req),  64'd1);
    ack_now();
    pulse_fs();
    check("ovf_wait_flag", 64'(o_rx_overflow), 64'd1);
    check("ovf_wait_noreq", 64'(o_wr_cmd_req), 64'd0);
    pulse_last();
    check("ovf_cnt", 64'(o_rx_frame_cnt), 64'd1);
    check("ovf_armed_noreq", 64'(o_wr_cmd_req), 64'd0);
    check("ovf_sb_empty", 64'(sb.size()), 64'd0);
    start_run(32'h1000_0000, 16'd870, 16'd100, 16'd2);
    check("ovf_cleared", 64'(o_rx_overflow), 64'd0);

    // Simultaneous wr_last + frame_start on frame 0 of 3.
    push_cmd(32'h1000_0000, 16'd872);
    pulse_fs();
    ack_now();
    push_cmd(32'h1000_0366, 16'd872);
    i_dma_wr_last = 1'b1;
    i_rx_frame_start = 1'b1;
    tick();
    i_dma_wr_last = 1'b0;
    i_rx_frame_start = 1'b0;
    check("sim_req",  64'(o_wr_cmd_req),   64'd1);
    check("sim_addr", 64'(o_wr_cmd_data[47:16]), 64'h1000_0366);
    check("sim_ovf",  64'(o_rx_overflow),  64'd0);
    check("sim_cnt",  64'(o_rx_frame_cnt), 64'd1);
    ack_now();
    check("sim_sb_empty", 64'(sb.size()), 64'd0);

    // Restart mid-run while a request is pending.
    start_run(32'h1000_0000, 16'd870, 16'd100, 16'd2);
    pulse_fs();
    check("rs_req_before", 64'(o_wr_cmd_req), 64'd1);
    start_run(32'h2000_0000, 16'd64, 16'd0, 16'd1);
    check("rs_req_drop", 64'(o_wr_cmd_req),   64'd0);
    check("rs_cnt",      64'(o_rx_frame_cnt), 64'd0);
    check("rs_busy",     64'(o_rx_busy),      64'd1);
    push_cmd(32'h2000_0000, 16'd64);
    pulse_fs();
    ack_now();
    check("rs_sb_empty", 64'(sb.size()), 64'd0);

    // Reset during WAIT_DONE; a following wr_last must be ignored.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wr_rst_req",  64'(o_wr_cmd_req),   64'd0);
    check("wr_rst_data", 64'(o_wr_cmd_data),  64'd0);
    check("wr_rst_cnt",  64'(o_rx_frame_cnt), 64'd0);
    check("wr_rst_busy", 64'(o_rx_busy),      64'd0);
    check("wr_rst_done", 64'(o_rx_done),      64'd0);
    check("wr_rst_ovf",  64'(o_rx_overflow),  64'd0);
    pulse_last();
    check("wr_rst_last_cnt",  64'(o_rx_frame_cnt), 64'd0);
    check("wr_rst_last_done", 64'(o_rx_done),      64'd0);

    // Soft reset aborts an armed run and clears overflow.
    start_run(32'h3000_0000, 16'd16, 16'd0, 16'd4);
    push_cmd(32'h3000_0000, 16'd16);
    pulse_fs();
    pulse_fs();
    ack_now();
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    check("srst_busy", 64'(o_rx_busy),     64'd0);
    check("srst_ovf",  64'(o_rx_overflow), 64'd0);
    check("srst_data", 64'(o_wr_cmd_data), 64'd0);
    check("srst_sb_empty", 64'(sb.size()), 64'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tlk2711_rx_cmd.md
# tlk2711_rx_cmd

RX-direction DMA command generator for the TLK2711 link: turns received-frame events into DMA write commands, placing each frame into a contiguous DDR buffer. It sits between the TLK2711 RX frame decoder, which reports frame starts, and the DMA write engine, which takes commands and reports per-frame completion. It is the receive-side counterpart of the TX read-command block and uses the same buffer layout (body frames, then one tail frame).

## Interface
- ADDR_WIDTH, 32, DDR byte-address width
- DLEN_WIDTH, 16, command byte-length width
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_soft_rst  in  1  register-driven abort; same effect as rst on state, counters and flags
- i_rx_start  in  1  one-cycle pulse; latches config, arms the block
- i_rx_base_addr  in  ADDR_WIDTH  buffer start byte address
- i_rx_packet_body  in  16  body frame length in bytes
- i_rx_packet_tail  in  16  tail frame length in bytes; 0 means no tail frame
- i_rx_body_num  in  16  number of body frames
- i_rx_frame_start  in  1  pulse from the decoder: a new frame header was detected
- o_wr_cmd_req  out  1  write-command request
- i_wr_cmd_ack  in  1  command accepted; meaningful only while req=1
- o_wr_cmd_data  out  DLEN_WIDTH+ADDR_WIDTH  {addr (high), byte length (low)}
- i_dma_wr_last  in  1  pulse: DMA finished writing the current frame
- o_rx_frame_cnt  out  16  frames completed in this run
- o_rx_busy  out  1  high in every state except IDLE
- o_rx_done  out  1  one-cycle pulse when the run completes
- o_rx_overflow  out  1  sticky; a frame start was dropped

## Operation
- States:
  - IDLE: waiting for a run
  - ARMED: waiting for a frame start
  - REQ: req held until ack
  - WAIT_DONE: waiting for i_dma_wr_last
- i_rx_start:
  - Latches base, body, tail and body_num. Config inputs are ignored until the next start.
  - Computes aligned lengths: len_a = {len[15:3] + |len[2:0], 3'b0}.
  - Clears the frame counter, sets addr = base, goes to ARMED.
- Frame k (0-based):
  - k < body_num: length = body_a.
  - k == body_num: length = tail_a.
  - The total run is body_num+1 frames, or body_num frames when tail=0.
- Address of frame k+1 = address of frame k + raw i_rx_packet_body. The increment uses the unaligned length, matching the TX layout.
- ARMED + frame_start → REQ.
- REQ + ack → WAIT_DONE.
- WAIT_DONE + wr_last:
  - Counter increments.
  - If this was the final frame: o_rx_done pulses and the state goes to IDLE.
  - Otherwise: the address advances and the state goes to ARMED.
- frame_start in REQ or WAIT_DONE: the frame is dropped and o_rx_overflow is set. The exception is the simultaneous case below.
- frame_start in IDLE: ignored, with no flag.
- Simultaneous wr_last + frame_start in WAIT_DONE, non-final frame: the state goes straight to REQ for the next frame and no overflow is flagged. If the frame was final, the frame_start is flagged as overflow.
- i_rx_start in any state restarts the run:
  - req drops, o_rx_overflow clears, config is relatched.
  - The DMA treats a req deassert without ack as a withdrawn command.
- i_soft_rst or rst: outputs return to reset values and the state goes to IDLE. rst has priority over i_rx_start, which has priority over i_soft_rst.
- body_num=0 with tail=0: i_rx_start produces o_rx_done the next cycle and returns to IDLE.

## Timing
- Reset values: o_wr_cmd_req=0, o_wr_cmd_data=0, o_rx_frame_cnt=0, o_rx_busy=0, o_rx_done=0, o_rx_overflow=0.
- i_rx_start at cycle T → ARMED and busy=1 at T+1. Aligned lengths are valid by T+2, and a frame start is accepted from T+1.
- frame_start at cycle F → o_wr_cmd_req=1 at F+1, with o_wr_cmd_data stable from F+1 until the ack cycle.
- Handshake: transfer happens on a cycle with req&ack. req=0 at A+1, where A is the transfer cycle; back-to-back requests are impossible.
- wr_last at cycle L:
  - Counter and address update at L+1.
  - o_rx_done pulses at L+1 (final frame only), with busy=0 in the same cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no carry-out.

## Structure
- Add to shared package tlk2711_pkg:
  - rx_cmd_state_t enum (IDLE, ARMED, REQ, WAIT_DONE)
  - ALIGN_BYTES = 8
  - Command-field packing function {addr, len}, shared with the TX command block
- One sub-module: tlk2711_len_align8, a registered 16-bit round-up-to-8. It is instantiated twice (body, tail) and is reusable by TX.

## Test plan
- Normal run: base=0x1000_0000, body=870, tail=100, body_num=2; ack after 3 cycles each → commands {0x1000_0000, 872}, {0x1000_0366, 872}, {0x1000_06CC, 104}; o_rx_done after the 3rd wr_last; frame_cnt=3.
- Tail=0: body=864, body_num=2 → exactly 2 commands of 864; done after the 2nd wr_last.
- Overflow: frame_start while req is pending and again in WAIT_DONE → overflow=1, no extra command, counter unaffected; next i_rx_start clears the flag.
- Simultaneous: wr_last and frame_start in the same cycle on frame 0 of 3 → req=1 next cycle with addr base+body, overflow=0.
- Restart mid-run: i_rx_start during REQ with base=0x2000_0000 → req drops at +1, counter=0, next command carries 0x2000_0000.
- Reset: rst during WAIT_DONE → all outputs at reset values next cycle, and a following wr_last is ignored.
